seven_seg_display_scheduler: RTL
================================

Name: seven_seg_display_scheduler

Overview:
Time-shares the two-digit seven-segment display between NUM_REQ byte producers, e.g. PS/2 scancode path and CPU debug port. Round-robin arbitration over valid/ready handshakes. Each accepted byte is held on the display for a minimum of HOLD_CYCLES clocks. Drives the 8-bit data input of the existing seven-segment hex decoder.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
HOLD_CYCLES, 50_000_000, minimum display time per accepted byte in clk cycles (>=1; 1 s at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester byte offered
req_data  in  NUM_REQ x 8  per-requester byte; stable while valid && !ready
req_ready  out  NUM_REQ  one-hot accept strobe, combinational
data_out  out  8  byte to the seven-segment decoder (high nibble disp1, low nibble disp0)
owner  out  $clog2(NUM_REQ)  index of requester whose byte is displayed
busy  out  1  hold window active

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- Reset values: data_out=0, owner=0, busy=0, state IDLE, rr pointer=0, hold counter=0. req_ready=0 while rst is high.
- States:
  - IDLE: busy=0.
  - HOLD: busy=1; counter runs HOLD_CYCLES-1 down to 0.
- Grant condition: state==IDLE, or state==HOLD with counter==0.
- Grant rules:
  - On the grant condition with any req_valid, pick the first valid index searching from the rr pointer upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 in that same cycle; the transfer completes that cycle.
  - Next edge: data_out<=req_data[g], owner<=g, counter<=HOLD_CYCLES-1, state<=HOLD, pointer<=(g+1) mod NUM_REQ.
- Grant condition with no valid: HOLD->IDLE; data_out and owner keep the last value (display never blanks).
- Each byte is displayed exactly HOLD_CYCLES cycles when other requests are pending. Back-to-back grants have zero bubble.
- At most one req_ready bit is high per cycle. req_ready is never high outside the grant condition, except under the optional feature.
- A requester dropping valid before ready is a protocol violation; behaviour is undefined and not checked.
- HOLD_CYCLES==1: counter width is 1; every HOLD cycle is a grant point.
- rst asserted mid-HOLD: immediate return to reset values; pending requests are re-arbitrated from pointer 0 after release.
- Counter width: $clog2(HOLD_CYCLES+1); no overflow, since the counter only loads HOLD_CYCLES-1 and decrements to 0.

Optional Feature:
SEVEN_SEG_PREEMPT_EN
- Defined: requester 0 is high priority. While in HOLD with owner!=0 and req_valid[0]=1, req_ready[0]=1 immediately. data_out<=req_data[0], owner<=0, counter reloads to HOLD_CYCLES-1, and the pointer is set to 1. Requester 0 cannot preempt itself.
- Undefined: pure round-robin; requester 0 waits for the grant condition.

Decomposition:
- Package seven_seg_pkg:
  - state enum (IDLE, HOLD)
  - SEG_DATA_W=8
  - typedef seg_byte_t
- Sub-module rr_arbiter: request vector and pointer in, one-hot grant and index out, purely combinational. Reusable for other shared peripherals.

Test Plan:
(NUM_REQ=2, HOLD_CYCLES=4)
1. Reset: rst=1 with req_valid=2'b11 -> req_ready=0, data_out=8'h00, busy=0, owner=0.
2. Single request: req_valid=01, req_data[0]=8'h1C at cycle t -> req_ready=01 at t. data_out=8'h1C and busy=1 for cycles t+1..t+4; busy=0 at t+5 with data_out still 8'h1C.
3. Contention: both valid continuously, data 8'hA1/8'hB2 -> grant order 0,1,0,1. data_out alternates A1/B2 every 4 cycles with no gap; req_ready is never 2'b11.
4. Pointer skip: req1 granted, then only req1 valid again at expiry -> req1 re-granted at counter==0; data_out updates with no IDLE cycle.
5. Reset mid-hold: rst asserted for 1 cycle at counter==2 -> data_out=0 and busy=0 asynchronously. After release with req1 valid, req0 idle -> req1 granted in the first IDLE cycle.
6. Preempt: req1 displayed, counter==2, req_valid[0] rises with 8'h55.
   - With SEVEN_SEG_PREEMPT_EN: req_ready[0]=1 same cycle; data_out=8'h55, owner=0 next cycle; held 4 cycles.
   - Without: req0 waits until counter==0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment display scheduler.
package seven_seg_pkg;

  localparam int SEG_DATA_W = 8;

  typedef logic [SEG_DATA_W-1:0] seg_byte_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/seven_seg_display_scheduler.sv
// Time-shares the two-digit hex display between byte producers.
// Define SEVEN_SEG_PREEMPT_EN to let requester 0 preempt a hold window.
module seven_seg_display_scheduler
  import seven_seg_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int HOLD_CYCLES = 50_000_000,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][SEG_DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output seg_byte_t                            data_out,
  output logic [IW-1:0]                        owner,
  output logic                                 busy
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic          grant_ok;
  logic          pre;
  logic          fire;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] ptr_nxt;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );

  assign grant_ok = (state == IDLE) || (cnt == '0);

`ifdef SEVEN_SEG_PREEMPT_EN
  assign pre = (state == HOLD) && (owner != '0) && req_valid[0];
`else
  assign pre = 1'b0;
`endif

  assign fire    = !rst && (pre || (grant_ok && arb_any));
  assign sel_idx = pre ? '0 : arb_idx;

  // Preemption by requester 0 yields pointer 1 through the same wrap rule.
  assign ptr_nxt = (sel_idx == IW'(NUM_REQ - 1)) ? '0
                 : sel_idx + IW'(1);

  always_comb begin
    req_ready = '0;
    if (fire) begin
      if (pre) req_ready = NUM_REQ'(1);
      else     req_ready = arb_gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      owner    <= '0;
      data_out <= '0;
    end else if (fire) begin
      state    <= HOLD;
      cnt      <= CW'(HOLD_CYCLES - 1);
      ptr      <= ptr_nxt;
      owner    <= sel_idx;
      data_out <= req_data[sel_idx];
    end else if (state == HOLD) begin
      // Expiry with nobody waiting: keep the last byte on the display.
      if (cnt == '0) state <= IDLE;
      else           cnt   <= cnt - CW'(1);
    end
  end

  assign busy = (state == HOLD);

endmodule
